fifo_stream_out: RTL and testbench

- Downstream drain stage for shift_register_fifo.
- Watches the FIFO's empty/data_out, issues pop, and re-presents the data as a registered valid/ready stream through a 2-entry skid buffer.
- fifo_pop depends only on local registers and fifo_empty, never on out_ready, so the FIFO pop path has no combinational dependency on the consumer.
- By construction, it never pops an empty FIFO, which is the FIFO's environmental constraint.

---
 rtl/fifo_stream_out_if.sv | 15 +
 rtl/fifo_stream_out.sv | 123 ++++++++++++
 tb/tb_fifo_stream_out.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_out_if.sv
// Purpose: valid/ready stream bundle carried out of fifo_stream_out.
// Ports (signals):
//   valid - stream valid, driven by the producer (master)
//   ready - consumer ready, driven by the consumer (slave)
//   data  - stream payload, WIDTH bits, driven by the producer
interface fifo_stream_out_if #(
    parameter int unsigned WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_stream_out.sv
// Purpose: drain stage for shift_register_fifo. Pops the show-ahead FIFO and
// re-presents its words as a registered valid/ready stream through a 2-entry
// skid buffer. The pop request never looks at the consumer's ready.
// Ports:
//   clk           - clock, rising edge
//   rst           - synchronous active-high reset
//   i_fifo_empty  - FIFO empty flag
//   i_fifo_data   - FIFO head data (show-ahead)
//   o_fifo_pop    - pop request, takes effect at the same edge
//   i_flush       - synchronous discard of buffered entries
//   o_stream      - valid/ready/data output stream (master)
//   o_occupancy   - number of buffered entries (0..2)
//   o_xfer_count  - wrapping count of completed output handshakes
module fifo_stream_out #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_fifo_empty,
    input  logic [WIDTH-1:0]        i_fifo_data,
    output logic                    o_fifo_pop,
    input  logic                    i_flush,
    fifo_stream_out_if.master       o_stream,
    output logic [1:0]              o_occupancy,
    output logic [CNT_W-1:0]        o_xfer_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_e;

    occ_e             r_state;
    occ_e             w_state_nxt;
    logic [WIDTH-1:0] r_e0;
    logic [WIDTH-1:0] r_e1;
    logic [CNT_W-1:0] r_xfer_count;

    logic             w_valid;
    logic             w_fire;
    logic             w_pop;
    logic             w_load_e0;
    logic             w_load_e1;
    logic             w_shift_e1;

    // Stream side and pop request: pop only from local state and FIFO flag.
    assign w_valid = (r_state != S_EMPTY);
    assign w_fire  = w_valid & o_stream.ready;
    assign w_pop   = ~rst & ~i_flush & ~i_fifo_empty & (r_state != S_TWO);

    // Occupancy next-state and entry load controls.
    always_comb begin
        w_state_nxt = r_state;
        w_load_e0   = 1'b0;
        w_load_e1   = 1'b0;
        w_shift_e1  = 1'b0;
        if (i_flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_pop) begin
                        w_load_e0   = 1'b1;
                        w_state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_pop && w_fire) begin
                        w_load_e0   = 1'b1;
                    end else if (w_pop) begin
                        w_load_e1   = 1'b1;
                        w_state_nxt = S_TWO;
                    end else if (w_fire) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // Pop is blocked here, so only a fire can move state.
                    if (w_fire) begin
                        w_shift_e1  = 1'b1;
                        w_state_nxt = S_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // State, entry and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_e0         <= '0;
            r_e1         <= '0;
            r_xfer_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_e0) begin
                r_e0 <= i_fifo_data;
            end else if (w_shift_e1) begin
                r_e0 <= r_e1;
            end
            if (w_load_e1) begin
                r_e1 <= i_fifo_data;
            end
            // A handshake in a flush cycle still counts.
            if (w_fire) begin
                r_xfer_count <= r_xfer_count + CNT_W'(1);
            end
        end
    end

    assign o_fifo_pop     = w_pop;
    assign o_stream.valid = w_valid;
    assign o_stream.data  = r_e0;
    assign o_occupancy    = 2'(r_state);
    assign o_xfer_count   = r_xfer_count;

endmodule

// File: tb/tb_fifo_stream_out.sv
// Purpose: self-checking bench for fifo_stream_out: a directed vector table,
// a few hand sequences, and randomized traffic against a queue-based model.
module tb_fifo_stream_out;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;
    logic             flush;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] xfer_count;

    fifo_stream_out_if #(.WIDTH(WIDTH)) s_if ();

    fifo_stream_out #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_pop   (fifo_pop),
        .i_flush      (flush),
        .o_stream     (s_if.master),
        .o_occupancy  (occupancy),
        .o_xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Directed vector: inputs for one cycle and the outputs expected before its edge.
    typedef struct {
        logic       rst;
        logic       flush;
        logic       rdy;
        logic       empty;
        logic [7:0] fdata;
        logic       e_pop;
        logic       e_valid;
        logic       c_data;
        logic [7:0] e_data;
        logic [1:0] e_occ;
        logic [3:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic rd, input logic em,
                                input logic [7:0] fd, input logic ep, input logic ev,
                                input logic cd, input logic [7:0] ed, input logic [1:0] eo,
                                input logic [3:0] ec);
        vec_t v;
        v.rst = r; v.flush = f; v.rdy = rd; v.empty = em; v.fdata = fd;
        v.e_pop = ep; v.e_valid = ev; v.c_data = cd; v.e_data = ed; v.e_occ = eo; v.e_cnt = ec;
        return v;
    endfunction

    // Reference model: FIFO contents and the words held by the drain stage.
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] mq[$];
    int               mcnt;

    task automatic run_cycle(input logic r, input logic f, input logic rdy);
        logic exp_pop;
        logic fire;
        rst        = r;
        flush      = f;
        s_if.ready = rdy;
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() != 0) ? fq[0] : '0;
        #1;
        exp_pop = !r && !f && (fq.size() != 0) && (mq.size() < 2);
        fire    = (mq.size() != 0) && rdy;
        chk("pop",   32'(fifo_pop),   32'(exp_pop));
        chk("valid", 32'(s_if.valid), 32'(mq.size() != 0));
        chk("occ",   32'(occupancy),  32'(mq.size()));
        chk("cnt",   32'(xfer_count), 32'(mcnt));
        if (mq.size() != 0) chk("data", 32'(s_if.data), 32'(mq[0]));
        if (occupancy == 2'd2) chk("pop_when_full", 32'(fifo_pop), 32'(0));
        @(posedge clk);
        if (r) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (fire) begin
                void'(mq.pop_front());
                mcnt = (mcnt + 1) % (1 << CNT_W);
            end
            if (f) mq.delete();
            else if (exp_pop) mq.push_back(fq.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t vt[$];

        rst        = 1'b1;
        flush      = 1'b0;
        s_if.ready = 1'b0;
        fifo_empty = 1'b0;
        fifo_data  = 8'h11;
        @(negedge clk);
        @(negedge clk);

        //          rst flush rdy empty data  pop val cd  data  occ cnt
        vt.push_back(mk(1, 0, 0, 0, 8'h11, 0, 0, 1, 8'h00, 0, 0));  // reset held, FIFO non-empty
        vt.push_back(mk(0, 0, 1, 0, 8'h11, 1, 0, 0, 8'h00, 0, 0));  // streaming
        vt.push_back(mk(0, 0, 1, 0, 8'h22, 1, 1, 1, 8'h11, 1, 0));
        vt.push_back(mk(0, 0, 1, 0, 8'h33, 1, 1, 1, 8'h22, 1, 1));
        vt.push_back(mk(0, 0, 1, 0, 8'h44, 1, 1, 1, 8'h33, 1, 2));
        vt.push_back(mk(0, 0, 1, 1, 8'h00, 0, 1, 1, 8'h44, 1, 3));
        vt.push_back(mk(0, 0, 1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 4));
        vt.push_back(mk(0, 0, 0, 0, 8'hA1, 1, 0, 0, 8'h00, 0, 4));  // backpressure
        vt.push_back(mk(0, 0, 0, 0, 8'hA2, 1, 1, 1, 8'hA1, 1, 4));
        vt.push_back(mk(0, 0, 0, 0, 8'hA3, 0, 1, 1, 8'hA1, 2, 4));
        vt.push_back(mk(0, 0, 0, 0, 8'hA3, 0, 1, 1, 8'hA1, 2, 4));
        vt.push_back(mk(0, 0, 1, 0, 8'hA3, 0, 1, 1, 8'hA1, 2, 4));  // first fire
        vt.push_back(mk(0, 0, 1, 0, 8'hA3, 1, 1, 1, 8'hA2, 1, 5));  // third pop
        vt.push_back(mk(0, 0, 1, 1, 8'h00, 0, 1, 1, 8'hA3, 1, 6));
        vt.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 7));
        vt.push_back(mk(0, 0, 0, 0, 8'h5A, 1, 0, 0, 8'h00, 0, 7));  // flush while full
        vt.push_back(mk(0, 0, 0, 0, 8'h5B, 1, 1, 1, 8'h5A, 1, 7));
        vt.push_back(mk(0, 1, 0, 0, 8'h5C, 0, 1, 1, 8'h5A, 2, 7));
        vt.push_back(mk(0, 0, 0, 0, 8'h5C, 1, 0, 0, 8'h00, 0, 7));
        vt.push_back(mk(0, 0, 0, 1, 8'h00, 0, 1, 1, 8'h5C, 1, 7));
        vt.push_back(mk(0, 1, 1, 1, 8'h00, 0, 1, 1, 8'h5C, 1, 7));  // fire during flush counts
        vt.push_back(mk(0, 0, 1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 8));
        vt.push_back(mk(0, 0, 0, 0, 8'h77, 1, 0, 0, 8'h00, 0, 8));  // mid-stream reset
        vt.push_back(mk(1, 0, 0, 0, 8'h78, 0, 1, 1, 8'h77, 1, 8));
        vt.push_back(mk(1, 0, 0, 0, 8'h78, 0, 0, 1, 8'h00, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 1, 8'h00, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            rst        = vt[i].rst;
            flush      = vt[i].flush;
            s_if.ready = vt[i].rdy;
            fifo_empty = vt[i].empty;
            fifo_data  = vt[i].fdata;
            #1;
            chk($sformatf("vec%0d_pop", i),   32'(fifo_pop),   32'(vt[i].e_pop));
            chk($sformatf("vec%0d_valid", i), 32'(s_if.valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d_occ", i),   32'(occupancy),  32'(vt[i].e_occ));
            chk($sformatf("vec%0d_cnt", i),   32'(xfer_count), 32'(vt[i].e_cnt));
            if (vt[i].c_data) chk($sformatf("vec%0d_data", i), 32'(s_if.data), 32'(vt[i].e_data));
            @(posedge clk);
            @(negedge clk);
        end

        // Counter wrap: 17 handshakes on a 4-bit counter leave it at 1.
        fq.delete();
        mq.delete();
        mcnt = 0;
        run_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) fq.push_back(WIDTH'(8'hC0 + i));
        for (int i = 0; i < 18; i++) run_cycle(1'b0, 1'b0, 1'b1);
        chk("wrap17", 32'(xfer_count), 32'(1));

        // Alternating ready with the FIFO always non-empty.
        for (int i = 0; i < 40; i++) begin
            while (fq.size() < 4) fq.push_back(WIDTH'($urandom));
            run_cycle(1'b0, 1'b0, (i % 2) == 0);
        end

        // Randomized traffic, occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic f;
            logic rd;
            if ($urandom_range(0, 2) != 0 && fq.size() < 8) fq.push_back(WIDTH'($urandom));
            r  = ($urandom_range(0, 79) == 0);
            f  = ($urandom_range(0, 39) == 0);
            rd = ($urandom_range(0, 3) != 0);
            if (i % 100 > 80) rd = 1'b0;
            run_cycle(r, f, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
